// File: rtl/vote_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vote_host_ctrl
//  Description : Host-side controller that operates a four-button voting
//                machine.
//                - A cast command presses one candidate button in vote mode.
//                - A read command switches to display mode, presses the
//                  button and samples the tally shown on led.
//                - Commands arrive on a valid/ready channel. Results leave
//                  on a valid/ready channel.
//  Ports       : clk, reset (async, active high)
//                cmd_valid/cmd_ready/cmd_op/cmd_cand  - command channel
//                rsp_valid/rsp_ready/rsp_op/rsp_cand/rsp_count - response
//                mode, button1..button4 - voting machine controls (registered)
//                led                    - voting machine tally display
//  Revision    : 1.0 - initial release
// ============================================================================
module vote_host_ctrl #(
  parameter int unsigned PRESS_CYCLES  = 20,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [1:0] cmd_cand,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_op,
  output logic [1:0] rsp_cand,
  output logic [7:0] rsp_count,
  output logic       mode,
  output logic       button1,
  output logic       button2,
  output logic       button3,
  output logic       button4,
  input  logic [7:0] led
);

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [7:0] C_PRESS_RELOAD  = 8'(PRESS_CYCLES - 1);
  localparam logic [7:0] C_GAP_RELOAD    = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] C_SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS  = 3'd1,
    GAP    = 3'd2,
    SETTLE = 3'd3,
    RPRESS = 3'd4,
    RGAP   = 3'd5,
    RESP   = 3'd6
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       w_cnt_zero;
  logic       w_xfer;
  logic [1:0] w_cand;
  logic [3:0] w_btn_nxt;
  logic       w_mode_nxt;

  logic [3:0] r_btn;
  logic       r_mode;
  logic       r_cmd_ready;
  logic       r_rsp_op;
  logic [1:0] r_rsp_cand;
  logic [7:0] r_rsp_count;

  // --------------------------------------------------------------------------
  // Next-state, counter and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cnt_zero  = (r_cnt == 8'd0);
    w_xfer      = cmd_valid && r_cmd_ready && (r_state == IDLE);
    // During IDLE the command fields are not yet registered, so the button
    // for the first PRESS/RPRESS cycle must come straight from the port.
    w_cand      = (r_state == IDLE) ? cmd_cand : r_rsp_cand;
    w_btn_nxt   = 4'b0000;
    w_mode_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_state_nxt = cmd_op ? SETTLE : PRESS;
        end
      end
      PRESS: begin
        if (w_cnt_zero) begin
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (w_cnt_zero) begin
          w_state_nxt = RESP;
        end
      end
      SETTLE: begin
        if (w_cnt_zero) begin
          w_state_nxt = RPRESS;
        end
      end
      RPRESS: begin
        if (w_cnt_zero) begin
          w_state_nxt = RGAP;
        end
      end
      RGAP: begin
        if (w_cnt_zero) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Single shared down-counter: reload on every state entry, otherwise
    // count down and rest at zero.
    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        PRESS, RPRESS: w_cnt_nxt = C_PRESS_RELOAD;
        GAP, RGAP:     w_cnt_nxt = C_GAP_RELOAD;
        SETTLE:        w_cnt_nxt = C_SETTLE_RELOAD;
        default:       w_cnt_nxt = 8'd0;
      endcase
    end else if (!w_cnt_zero) begin
      w_cnt_nxt = r_cnt - 8'd1;
    end

    // Buttons and mode are registered from the next state, so they change
    // on the same edge as the state. The button mask is one-hot or zero.
    if ((w_state_nxt == PRESS) || (w_state_nxt == RPRESS)) begin
      w_btn_nxt = 4'b0001 << w_cand;
    end
    // Display mode is held from SETTLE through RGAP. Those phases bracket
    // the read press with buttons-low cycles, so mode only toggles while
    // every button is released.
    if ((w_state_nxt == SETTLE) || (w_state_nxt == RPRESS) ||
        (w_state_nxt == RGAP)) begin
      w_mode_nxt = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_btn       <= 4'b0000;
      r_mode      <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rsp_op    <= 1'b0;
      r_rsp_cand  <= 2'd0;
      r_rsp_count <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_btn       <= w_btn_nxt;
      r_mode      <= w_mode_nxt;
      // Registered ready keeps cmd_ready low while reset is held and raises
      // it on the first edge after release.
      r_cmd_ready <= (w_state_nxt == IDLE);
      if (w_xfer) begin
        r_rsp_op    <= cmd_op;
        r_rsp_cand  <= cmd_cand;
        r_rsp_count <= 8'd0;
      end else if ((r_state == RPRESS) && w_cnt_zero) begin
        // Last cycle of the display-mode press: the tally is on led.
        r_rsp_count <= led;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_op    = r_rsp_op;
  assign rsp_cand  = r_rsp_cand;
  assign rsp_count = r_rsp_count;
  assign mode      = r_mode;
  assign button1   = r_btn[0];
  assign button2   = r_btn[1];
  assign button3   = r_btn[2];
  assign button4   = r_btn[3];

endmodule
`default_nettype wire

// File: tb/tb_vote_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vote_host_ctrl
//  Description : Self-checking bench for vote_host_ctrl. Two instances are
//                exercised: one with default timing and one with all phase
//                lengths set to one cycle. A behavioural voting machine
//                drives led. Expected behaviour comes from a per-cycle
//                timeline built from the phase lengths and from a vote
//                scoreboard kept per command.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vote_host_ctrl;

  localparam int PC [0:1] = '{20, 1};
  localparam int GC [0:1] = '{4, 1};
  localparam int SC [0:1] = '{2, 1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]      cmd_valid, cmd_op, rsp_ready, led_ovr;
  logic [1:0][1:0] cmd_cand;
  logic [1:0][7:0] led, led_force;
  wire  [1:0]      cmd_ready, rsp_valid, rsp_op, mode;
  wire  [1:0][1:0] rsp_cand;
  wire  [1:0][7:0] rsp_count;
  wire  [1:0][3:0] btn;

  int checks = 0;
  int errors = 0;
  int tally     [2][4] = '{default: 0};
  int exp_votes [2][4] = '{default: 0};
  logic [1:0][3:0] btn_prev = '0;
  logic [1:0]      mode_prev = '0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    vote_host_ctrl #(
      .PRESS_CYCLES (PC[gi]),
      .GAP_CYCLES   (GC[gi]),
      .SETTLE_CYCLES(SC[gi])
    ) u_dut (
      .clk      (clk),
      .reset    (rst),
      .cmd_valid(cmd_valid[gi]),
      .cmd_ready(cmd_ready[gi]),
      .cmd_op   (cmd_op[gi]),
      .cmd_cand (cmd_cand[gi]),
      .rsp_valid(rsp_valid[gi]),
      .rsp_ready(rsp_ready[gi]),
      .rsp_op   (rsp_op[gi]),
      .rsp_cand (rsp_cand[gi]),
      .rsp_count(rsp_count[gi]),
      .mode     (mode[gi]),
      .button1  (btn[gi][0]),
      .button2  (btn[gi][1]),
      .button3  (btn[gi][2]),
      .button4  (btn[gi][3]),
      .led      (led[gi])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Voting machine model: display mode shows the tally of the pressed button.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      led[d] = 8'd0;
      if (led_ovr[d]) begin
        led[d] = led_force[d];
      end else if (mode[d]) begin
        for (int k = 0; k < 4; k++) begin
          if (btn[d][k]) led[d] = tally[d][k][7:0];
        end
      end
    end
  end

  // Machine vote counting plus per-cycle invariants of the button/mode pins.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        chk("one_button", 32'($countones(btn[d]) <= 1), 32'd1);
        if (mode[d] !== mode_prev[d]) begin
          chk("mode_change_quiet", 32'({btn[d], btn_prev[d]}), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
          if (!mode[d] && btn[d][k] && !btn_prev[d][k]) tally[d][k] <= tally[d][k] + 1;
        end
      end
      btn_prev[d]  <= btn[d];
      mode_prev[d] <= mode[d];
    end
  end

  // One full command on instance d, called and returning at a negedge.
  task automatic do_cmd(input int d, input bit op, input bit [1:0] c, input bit hold,
                        input int rdy_wait, input bit toggle_led);
    int         limit;
    int         waitc;
    logic [3:0] oh;
    logic [3:0] ebtn;
    logic       emode;
    logic [7:0] ecnt;
    oh = 4'b0001 << c;
    cmd_valid[d] = 1'b1;
    cmd_op[d]    = op;
    cmd_cand[d]  = c;
    waitc = 0;
    while (cmd_ready[d] !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk("accept_wait", 32'(cmd_ready[d]), 32'd1);
    if (cmd_ready[d] !== 1'b1) begin
      cmd_valid[d] = 1'b0;
      return;
    end
    limit = (op ? SC[d] : 0) + PC[d] + GC[d] + 1;
    for (int t = 1; t <= limit; t++) begin
      @(negedge clk);
      if (!hold) cmd_valid[d] = 1'b0;
      if (op) begin
        emode = (t <= limit - 1);
        ebtn  = (t > SC[d] && t <= SC[d] + PC[d]) ? oh : 4'b0000;
      end else begin
        emode = 1'b0;
        ebtn  = (t <= PC[d]) ? oh : 4'b0000;
      end
      chk("mode", 32'(mode[d]), 32'(emode));
      chk("buttons", 32'(btn[d]), 32'(ebtn));
      chk("rsp_valid", 32'(rsp_valid[d]), 32'(t == limit));
      chk("cmd_ready_busy", 32'(cmd_ready[d]), 32'd0);
    end
    ecnt = op ? exp_votes[d][c][7:0] : 8'd0;
    chk("rsp_op", 32'(rsp_op[d]), 32'(op));
    chk("rsp_cand", 32'(rsp_cand[d]), 32'(c));
    chk("rsp_count", 32'(rsp_count[d]), 32'(ecnt));
    for (int w = 0; w < rdy_wait; w++) begin
      if (toggle_led) begin
        led_ovr[d]   = 1'b1;
        led_force[d] = 8'($urandom);
      end
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_count", 32'(rsp_count[d]), 32'(ecnt));
      chk("hold_buttons", 32'(btn[d]), 32'd0);
      chk("hold_mode", 32'(mode[d]), 32'd0);
      chk("hold_cmd_ready", 32'(cmd_ready[d]), 32'd0);
    end
    led_ovr[d]   = 1'b0;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk("post_hs_valid", 32'(rsp_valid[d]), 32'd0);
    chk("post_hs_ready", 32'(cmd_ready[d]), 32'd1);
    if (!op) exp_votes[d][c] = exp_votes[d][c] + 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = '0;
    cmd_op    = '0;
    cmd_cand  = '0;
    rsp_ready = '0;
    led_ovr   = '0;
    led_force = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_cmd_ready", 32'(cmd_ready[d]), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("reset_mode", 32'(mode[d]), 32'd0);
      chk("reset_buttons", 32'(btn[d]), 32'd0);
      chk("reset_rsp", 32'({rsp_op[d], rsp_cand[d], rsp_count[d]}), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("ready_after_reset", 32'(cmd_ready[d]), 32'd1);

    // Default timing: cast to candidate 2, then three casts and a read.
    do_cmd(0, 1'b0, 2'd2, 1'b0, 0, 1'b0);
    repeat (3) do_cmd(0, 1'b0, 2'd0, 1'b0, 1, 1'b0);
    do_cmd(0, 1'b1, 2'd0, 1'b0, 0, 1'b0);
    // Two more votes, then a read held off for 50 cycles while led toggles.
    repeat (2) do_cmd(0, 1'b0, 2'd0, 1'b0, 0, 1'b0);
    do_cmd(0, 1'b1, 2'd0, 1'b0, 50, 1'b1);
    // cmd_valid held continuously across two commands.
    do_cmd(0, 1'b0, 2'd3, 1'b1, 2, 1'b0);
    do_cmd(0, 1'b0, 2'd3, 1'b1, 0, 1'b0);
    cmd_valid[0] = 1'b0;
    do_cmd(0, 1'b1, 2'd3, 1'b0, 0, 1'b0);

    // One-cycle phases.
    do_cmd(1, 1'b0, 2'd1, 1'b0, 0, 1'b0);
    do_cmd(1, 1'b1, 2'd1, 1'b0, 0, 1'b0);
    do_cmd(1, 1'b0, 2'd2, 1'b1, 0, 1'b0);
    do_cmd(1, 1'b1, 2'd2, 1'b1, 0, 1'b0);
    cmd_valid[1] = 1'b0;

    // Randomized command streams.
    for (int i = 0; i < 12; i++) begin
      do_cmd(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0,
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 40; i++) begin
      do_cmd(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0,
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a cast press.
    cmd_valid[0] = 1'b1;
    cmd_op[0]    = 1'b0;
    cmd_cand[0]  = 2'd1;
    chk("abort_accept", 32'(cmd_ready[0]), 32'd1);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_btn_before", 32'(btn[0]), 32'b0010);
    #2 rst = 1'b1;
    #1;
    chk("abort_btn_async", 32'(btn[0]), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", 32'(cmd_ready[0]), 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid[0]), 32'd0);
      chk("abort_no_btn", 32'(btn[0]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
